// File: rtl/nor_tree_pkg.sv
// Shared definitions for the pipelined NOR/OR reduction tree.
//   MODE_NOR / MODE_OR : per-channel polarity encoding of in_mode.
//   levels(width)      : pipeline depth, max(1, clog2(width)).
//   level_count(w, k)  : number of elements left at tree level k, ceil(w / 2^k).
package nor_tree_pkg;

  localparam logic MODE_NOR = 1'b0;
  localparam logic MODE_OR  = 1'b1;

  function automatic int levels(input int width);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << n) < width) n = n + 1;
    end
    return (n < 1) ? 1 : n;
  endfunction

  function automatic int level_count(input int width, input int k);
    return (width + (1 << k) - 1) >> k;
  endfunction

endpackage

// File: rtl/nor_tree_stage.sv
// One pipeline level of the reduction tree, shared by all channels.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : upstream handshake (in_ready is combinational)
//   in_data             : CHANNELS x IN_W elements, channel c at [c*IN_W +: IN_W]
//   in_mode             : per-channel polarity travelling with the beat
//   out_valid/out_ready : downstream handshake
//   out_data            : CHANNELS x OUT_W pairwise-ORed elements
//   out_mode            : registered copy of in_mode
module nor_tree_stage
  import nor_tree_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int IN_W     = 8,
  parameter int OUT_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*IN_W-1:0]  in_data,
  input  logic [CHANNELS-1:0]       in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*OUT_W-1:0] out_data,
  output logic [CHANNELS-1:0]       out_mode
);

  logic                      valid_reg;
  logic [CHANNELS*OUT_W-1:0] data_reg;
  logic [CHANNELS-1:0]       mode_reg;
  logic [CHANNELS*OUT_W-1:0] or_next;

  genvar gi, gj;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : gen_ch
      for (gj = 0; gj < OUT_W; gj++) begin : gen_pair
        if (2 * gj + 1 < IN_W) begin : g_pair
          assign or_next[gi*OUT_W+gj] = in_data[gi*IN_W+2*gj] | in_data[gi*IN_W+2*gj+1];
        end else begin : g_odd
          // Unpaired element: OR with the identity 0 is a plain pass-through.
          assign or_next[gi*OUT_W+gj] = in_data[gi*IN_W+2*gj];
        end
      end
    end
  endgenerate

  // Stage can take a new beat when empty or when its current beat leaves.
  assign in_ready = !valid_reg || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      mode_reg  <= '0;
    end else if (in_ready) begin
      valid_reg <= in_valid;
      if (in_valid) begin
        data_reg <= or_next;
        mode_reg <= in_mode;
      end
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_mode  = mode_reg;

endmodule

// File: rtl/nor_tree_pipe.sv
// Pipelined wide NOR/OR detector: each of CHANNELS channels reduces WIDTH
// bits to one through a balanced 2-input OR tree with one register per
// level, then applies per-beat polarity (in_mode bit 0 = NOR, 1 = OR).
// Latency is LEVELS = max(1, clog2(WIDTH)) cycles, one beat per cycle,
// full valid/ready backpressure.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake
//   in_data             : channel c at [c*WIDTH +: WIDTH]
//   in_mode             : per-channel polarity, captured with the data
//   out_valid/out_ready : output handshake
//   out_data            : one result bit per channel
//   sticky_clr, sticky  : only with NOR_TREE_PIPE_STICKY_EN; sticky[c] latches
//                         any transferred out_data[c]=1 until cleared
module nor_tree_pipe
  import nor_tree_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
`ifdef NOR_TREE_PIPE_STICKY_EN
  input  logic                      sticky_clr,
  output logic [CHANNELS-1:0]       sticky,
`endif
  output logic [CHANNELS-1:0]       out_data
);

  localparam int LEVELS = levels(WIDTH);

  logic [LEVELS:0]     stage_valid;
  logic [CHANNELS-1:0] stage_mode [LEVELS+1];
  logic [CHANNELS-1:0] tree_or;
  logic [CHANNELS-1:0] polarity;

  assign stage_valid[0] = in_valid;
  assign stage_mode[0]  = in_mode;

  genvar gi;
  generate
    for (gi = 0; gi < LEVELS; gi++) begin : gen_stage
      localparam int IN_W  = level_count(WIDTH, gi);
      localparam int OUT_W = level_count(WIDTH, gi + 1);

      logic [CHANNELS*IN_W-1:0]  data_i;
      logic [CHANNELS*OUT_W-1:0] data_o;
      logic                      ready_i;
      logic                      ready_o;

      if (gi == 0) begin : g_first
        assign data_i = in_data;
      end else begin : g_rest
        assign data_i = gen_stage[gi-1].data_o;
      end

      // Ready ripples backwards combinationally so a full pipe still
      // accepts on the same edge that the tail drains.
      if (gi == LEVELS - 1) begin : g_last
        assign ready_o = out_ready;
      end else begin : g_mid
        assign ready_o = gen_stage[gi+1].ready_i;
      end

      nor_tree_stage #(
        .CHANNELS(CHANNELS),
        .IN_W    (IN_W),
        .OUT_W   (OUT_W)
      ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .in_valid (stage_valid[gi]),
        .in_ready (ready_i),
        .in_data  (data_i),
        .in_mode  (stage_mode[gi]),
        .out_valid(stage_valid[gi+1]),
        .out_ready(ready_o),
        .out_data (data_o),
        .out_mode (stage_mode[gi+1])
      );
    end
  endgenerate

  assign in_ready = gen_stage[0].ready_i;
  assign tree_or  = gen_stage[LEVELS-1].data_o;

  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : gen_pol
      assign polarity[gi] = (stage_mode[LEVELS][gi] == MODE_OR) ? tree_or[gi] : ~tree_or[gi];
    end
  endgenerate

  // Gating by valid keeps out_data at 0 while reset is asserted, since the
  // cleared NOR polarity would otherwise present all ones.
  assign out_valid = stage_valid[LEVELS];
  assign out_data  = out_valid ? polarity : '0;

`ifdef NOR_TREE_PIPE_STICKY_EN
  logic [CHANNELS-1:0] sticky_reg;
  logic [CHANNELS-1:0] sticky_next;

  // Clear first, then OR in the transferring result so a set on the same
  // edge survives the clear.
  always_comb begin
    sticky_next = sticky_clr ? '0 : sticky_reg;
    if (out_valid && out_ready) sticky_next = sticky_next | out_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_reg <= '0;
    else     sticky_reg <= sticky_next;
  end

  assign sticky = sticky_reg;
`endif

endmodule

// File: tb/tb_nor_tree_pipe.sv
// Self-checking bench for nor_tree_pipe: main 8x4 instance plus WIDTH=5 and
// WIDTH=1 single-channel instances for the odd-width corners.
module tb_nor_tree_pipe;

  localparam int L8 = 3;
  localparam int L5 = 3;
  localparam int L1 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data;
  logic [3:0]  in_mode, out_data;

  logic       v5, r5, ov5, m5;
  logic [4:0] d5;
  logic [0:0] od5;
  logic       v1, r1, ov1, m1, d1;
  logic [0:0] od1;

`ifdef NOR_TREE_PIPE_STICKY_EN
  logic       sticky_clr;
  logic [3:0] sticky;
  logic [0:0] sticky5, sticky1;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;

  always #5 clk = ~clk;

  nor_tree_pipe #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef NOR_TREE_PIPE_STICKY_EN
    .sticky_clr(sticky_clr), .sticky(sticky),
`endif
    .out_data(out_data)
  );

  nor_tree_pipe #(.WIDTH(5), .CHANNELS(1)) dut5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_ready(r5),
    .in_data(d5), .in_mode(m5), .out_valid(ov5), .out_ready(1'b1),
`ifdef NOR_TREE_PIPE_STICKY_EN
    .sticky_clr(1'b0), .sticky(sticky5),
`endif
    .out_data(od5)
  );

  nor_tree_pipe #(.WIDTH(1), .CHANNELS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1),
    .in_data(d1), .in_mode(m1), .out_valid(ov1), .out_ready(1'b1),
`ifdef NOR_TREE_PIPE_STICKY_EN
    .sticky_clr(1'b0), .sticky(sticky1),
`endif
    .out_data(od1)
  );

  // Reference: a channel is "any" when its byte is non-zero; mode picks
  // whether that or its complement is reported.
  function automatic logic [3:0] model8(input logic [31:0] d, input logic [3:0] m);
    logic [3:0] r;
    logic [7:0] b;
    for (int c = 0; c < 4; c++) begin
      b = d[c*8 +: 8];
      r[c] = m[c] ? (b != 8'h00) : (b == 8'h00);
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_data();
    logic [31:0] r;
    r = $urandom;
    for (int c = 0; c < 4; c++) begin
      if ($urandom_range(0, 2) == 0) r[c*8 +: 8] = 8'h00;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Scoreboard: expected results queued at acceptance, compared in order
  // at each output transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_extra: got beat %b, required no beat", out_data);
        end else begin
          mon_exp = exp_q.pop_front();
          $display("out beat data=%b exp=%b", out_data, mon_exp);
          check("scoreboard", {28'd0, out_data}, {28'd0, mon_exp});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model8(in_data, in_mode));
    end
  end

  // Presents one beat into an empty pipe and checks exact latency.
  task automatic send_one(input logic [31:0] d, input logic [3:0] m,
                          input logic [3:0] exp, input int clr_at);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_mode = m;
    for (int k = 0; k <= L8; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
`ifdef NOR_TREE_PIPE_STICKY_EN
      sticky_clr = (k == clr_at);
`endif
      @(negedge clk);
      if (k == 0) check("dir_in_ready", {31'd0, in_ready}, 32'd1);
      check("dir_latency", {31'd0, out_valid}, {31'd0, (k == L8)});
      if (k == L8) check("dir_data", {28'd0, out_data}, {28'd0, exp});
    end
    @(posedge clk); #1;
`ifdef NOR_TREE_PIPE_STICKY_EN
    sticky_clr = 1'b0;
`endif
  endtask

  task automatic send_small(input int which, input logic [4:0] d, input logic m, input logic exp);
    int lat;
    lat = (which == 5) ? L5 : L1;
    @(posedge clk); #1;
    if (which == 5) begin v5 = 1'b1; d5 = d; m5 = m; end
    else begin v1 = 1'b1; d1 = d[0]; m1 = m; end
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        v5 = 1'b0; v1 = 1'b0;
      end
      @(negedge clk);
      if (which == 5) begin
        check("w5_latency", {31'd0, ov5}, {31'd0, (k == lat)});
        if (k == lat) check("w5_data", {31'd0, od5}, {31'd0, exp});
      end else begin
        check("w1_latency", {31'd0, ov1}, {31'd0, (k == lat)});
        if (k == lat) check("w1_data", {31'd0, od1}, {31'd0, exp});
      end
    end
    $display("small w=%0d d=%b mode=%b exp=%b", which, d, m, exp);
    @(posedge clk); #1;
  endtask

  task automatic back_to_back();
    int run, best;
    run = 0; best = 0;
    for (int cyc = 0; cyc < 16 + L8 + 2; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 16) begin
        in_valid = 1'b1; in_data = rand_data(); in_mode = 4'($urandom_range(0, 15));
      end else in_valid = 1'b0;
      @(negedge clk);
      if (cyc < 16) check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      if (out_valid) begin
        run++;
        if (run > best) best = run;
      end else run = 0;
    end
    check("b2b_out_run", best, 16);
  endtask

  task automatic backpressure();
    int sent, stall_acc;
    logic pend;
    logic [3:0] held;
    sent = 0; stall_acc = 0; pend = 1'b0; held = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      out_ready = (cyc >= 6);
      if (!pend) begin
        if (sent < 10) begin
          in_valid = 1'b1; in_data = rand_data(); in_mode = 4'($urandom_range(0, 15));
        end else in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        sent++;
        if (cyc < 6) stall_acc++;
        pend = 1'b0;
      end else pend = in_valid;
      if (cyc >= 3 && cyc < 6) begin
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        if (cyc == 3) held = out_data;
        else check("bp_hold", {28'd0, out_data}, {28'd0, held});
      end
    end
    check("bp_accepted_in_stall", stall_acc, 3);
    check("bp_sent", sent, 10);
    @(posedge clk); #1;
    check("bp_drain", exp_q.size(), 0);
  endtask

  task automatic random_traffic(input int cycles);
    logic pend;
    pend = 1'b0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 9) < 6);
      if (!pend) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_data  = rand_data();
        in_mode  = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      pend = in_valid && !in_ready;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (L8 + 3) @(negedge clk);
    @(posedge clk); #1;
    check("rand_drain", exp_q.size(), 0);
  endtask

  task automatic reset_mid_stall();
    int acc;
    acc = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 32'hFFFF_FFFF; in_mode = 4'b0000;
      @(negedge clk);
      if (in_valid && in_ready) acc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_accepted", acc, 3);
    check("rst_pre_full", {31'd0, out_valid}, 32'd1);
    check("rst_pre_stall", {31'd0, in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", {31'd0, out_valid}, 32'd0);
    check("rst_async_data", {28'd0, out_data}, 32'd0);
    exp_q.delete();
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_no_stale", {31'd0, out_valid}, 32'd0);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic [3:0]  m;
    logic [3:0]  exp;
  } vec_t;

  typedef struct {
    int         which;
    logic [4:0] d;
    logic       m;
    logic       exp;
  } small_vec_t;

  vec_t       tbl[4];
  small_vec_t stbl[7];

  initial begin
    tbl[0] = '{32'hFF80_0100, 4'b0000, 4'b0001};
    tbl[1] = '{32'hFF80_0100, 4'b1111, 4'b1110};
    tbl[2] = '{32'h0000_0000, 4'b0000, 4'b1111};
    tbl[3] = '{32'h0102_0408, 4'b1010, 4'b1010};
    stbl[0] = '{5, 5'b10000, 1'b0, 1'b0};
    stbl[1] = '{5, 5'b00000, 1'b0, 1'b1};
    stbl[2] = '{5, 5'b00001, 1'b1, 1'b1};
    stbl[3] = '{5, 5'b00000, 1'b1, 1'b0};
    stbl[4] = '{1, 5'b00001, 1'b0, 1'b0};
    stbl[5] = '{1, 5'b00000, 1'b0, 1'b1};
    stbl[6] = '{1, 5'b00001, 1'b1, 1'b1};

    in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
    v5 = 1'b0; d5 = '0; m5 = 1'b0; v1 = 1'b0; d1 = 1'b0; m1 = 1'b0;
`ifdef NOR_TREE_PIPE_STICKY_EN
    sticky_clr = 1'b0;
`endif
    #1 rst = 1'b1;
    #2;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", {28'd0, out_data}, 32'd0);
    #19 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 4; i++) begin
      $display("directed vec %0d data=%h mode=%b exp=%b", i, tbl[i].d, tbl[i].m, tbl[i].exp);
      send_one(tbl[i].d, tbl[i].m, tbl[i].exp, -1);
    end
    for (int i = 0; i < 7; i++) send_small(stbl[i].which, stbl[i].d, stbl[i].m, stbl[i].exp);

    back_to_back();
    backpressure();
    random_traffic(80);
    reset_mid_stall();

`ifdef NOR_TREE_PIPE_STICKY_EN
    @(posedge clk); #1 sticky_clr = 1'b1;
    @(posedge clk); #1 sticky_clr = 1'b0;
    @(negedge clk);
    check("sticky_clear_first", {28'd0, sticky}, 32'd0);
    send_one(32'h0001_0000, 4'b1111, 4'b0100, -1);
    @(negedge clk);
    check("sticky_set", {28'd0, sticky}, 32'h4);
    repeat (2) @(negedge clk);
    check("sticky_persist", {28'd0, sticky}, 32'h4);
    send_one(32'h0001_0000, 4'b1111, 4'b0100, L8);
    @(negedge clk);
    check("sticky_set_wins", {28'd0, sticky}, 32'h4);
    @(posedge clk); #1 sticky_clr = 1'b1;
    @(posedge clk); #1 sticky_clr = 1'b0;
    @(negedge clk);
    check("sticky_clr_alone", {28'd0, sticky}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
